// File: rtl/tile_round_controller.sv
`timescale 1ns/1ps
// Tile-matching round sequencer: switch edge detection, two-tile reveal with blink,
// match resolution and all-matched detection for one game on the DE1-SoC.
module tile_round_controller #(
  parameter int          SHOW_CYCLES  = 25000000,
  parameter int          BLINK_CYCLES = 6250000,
  parameter logic [29:0] TILE_COLORS  = 30'h2D2E28D1
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       quit,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [3:0] hex_a,
  output logic [3:0] hex_b,
  output logic [7:0] move_count,
  output logic       all_matched,
  output logic [2:0] game_state
);

  // start and quit are single-cycle strobes from the mode FSM; there is no ready
  // back-pressure, a strobe is consumed in the cycle it is high or dropped.

  localparam int SHW_W = $clog2(SHOW_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [SHW_W-1:0] SHOW_LOAD  = SHW_W'(SHOW_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLINK_LOAD = BLK_W'(BLINK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PICK1   = 3'd1,
    S_PICK2   = 3'd2,
    S_SHOW    = 3'd3,
    S_RESOLVE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        sync1_q, sync1_d;
  logic [9:0]        sync2_q, sync2_d;
  logic [9:0]        prev_q, prev_d;
  logic [9:0]        matched_q, matched_d;
  logic [9:0]        revealed_q, revealed_d;
  logic [3:0]        idx1_q, idx1_d;
  logic [3:0]        idx2_q, idx2_d;
  logic [3:0]        hex_a_q, hex_a_d;
  logic [3:0]        hex_b_q, hex_b_d;
  logic [7:0]        move_count_q, move_count_d;
  logic [SHW_W-1:0]  show_cnt_q, show_cnt_d;
  logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              vis_q, vis_d;

  logic [9:0]        sel;
  logic              sel_any;
  logic [3:0]        sel_idx;
  logic              pair_match;
  logic [9:0]        matched_next;

  function automatic logic [3:0] tile_color(input logic [3:0] idx);
    logic [3:0] c;
    c = 4'h0;
    for (int k = 0; k < 10; k++) begin
      if (idx == 4'(k)) c = {1'b0, TILE_COLORS[3*k +: 3]};
    end
    return c;
  endfunction

  assign sel = sync2_q & ~prev_q & ~matched_q & ~revealed_q;

  // Lowest index wins; the other simultaneous edges are lost on purpose.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (sel[i]) begin
        sel_any = 1'b1;
        sel_idx = 4'(i);
      end
    end
  end

  always_comb begin
    pair_match   = (tile_color(idx1_q) == tile_color(idx2_q));
    matched_next = matched_q;
    if (pair_match) matched_next = matched_q | (10'd1 << idx1_q) | (10'd1 << idx2_q);
  end

  always_comb begin
    state_d      = state_q;
    sync1_d      = SW;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    matched_d    = matched_q;
    revealed_d   = revealed_q;
    idx1_d       = idx1_q;
    idx2_d       = idx2_q;
    hex_a_d      = hex_a_q;
    hex_b_d      = hex_b_q;
    move_count_d = move_count_q;
    show_cnt_d   = show_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    vis_d        = vis_q;

    if (quit && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      matched_d  = 10'd0;
      revealed_d = 10'd0;
      hex_a_d    = 4'hF;
      hex_b_d    = 4'hF;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d      = S_PICK1;
            matched_d    = 10'd0;
            revealed_d   = 10'd0;
            move_count_d = 8'd0;
            hex_a_d      = 4'hF;
            hex_b_d      = 4'hF;
          end
        end
        S_PICK1: begin
          if (sel_any) begin
            revealed_d = revealed_q | (10'd1 << sel_idx);
            idx1_d     = sel_idx;
            hex_a_d    = tile_color(sel_idx);
            state_d    = S_PICK2;
          end
        end
        S_PICK2: begin
          if (sel_any) begin
            revealed_d  = revealed_q | (10'd1 << sel_idx);
            idx2_d      = sel_idx;
            hex_b_d     = tile_color(sel_idx);
            if (move_count_q != 8'hFF) move_count_d = move_count_q + 8'd1;
            show_cnt_d  = SHOW_LOAD;
            blink_cnt_d = BLINK_LOAD;
            vis_d       = 1'b1;
            state_d     = S_SHOW;
          end
        end
        S_SHOW: begin
          if (show_cnt_q == '0) state_d = S_RESOLVE;
          else show_cnt_d = show_cnt_q - 1'b1;
          if (blink_cnt_q == '0) begin
            blink_cnt_d = BLINK_LOAD;
            vis_d       = ~vis_q;
          end else begin
            blink_cnt_d = blink_cnt_q - 1'b1;
          end
        end
        S_RESOLVE: begin
          matched_d  = matched_next;
          revealed_d = 10'd0;
          hex_a_d    = 4'hF;
          hex_b_d    = 4'hF;
          state_d    = (matched_next == 10'h3FF) ? S_DONE : S_PICK1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      sync1_q      <= 10'd0;
      sync2_q      <= 10'd0;
      prev_q       <= 10'd0;
      matched_q    <= 10'd0;
      revealed_q   <= 10'd0;
      idx1_q       <= 4'd0;
      idx2_q       <= 4'd0;
      hex_a_q      <= 4'hF;
      hex_b_q      <= 4'hF;
      move_count_q <= 8'd0;
      show_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      vis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      matched_q    <= matched_d;
      revealed_q   <= revealed_d;
      idx1_q       <= idx1_d;
      idx2_q       <= idx2_d;
      hex_a_q      <= hex_a_d;
      hex_b_q      <= hex_b_d;
      move_count_q <= move_count_d;
      show_cnt_q   <= show_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      vis_q        <= vis_d;
    end
  end

  // Blanking during the reveal is applied at the output so the stored colors survive.
  assign hex_a       = (state_q == S_SHOW && !vis_q) ? 4'hF : hex_a_q;
  assign hex_b       = (state_q == S_SHOW && !vis_q) ? 4'hF : hex_b_q;
  assign LEDR        = (state_q == S_DONE) ? 10'h3FF : (matched_q | revealed_q);
  assign move_count  = move_count_q;
  assign all_matched = (state_q == S_DONE);
  assign game_state  = state_q;

endmodule

// File: tb/tb_tile_round_controller.sv
`timescale 1ns/1ps
// Directed bench for tile_round_controller with short reveal/blink timing.
module tb_tile_round_controller;

  localparam int SHOW_CYCLES  = 8;
  localparam int BLINK_CYCLES = 2;

  logic       CLOCK_50;
  logic       resetn;
  logic       start;
  logic       quit;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [3:0] hex_a;
  logic [3:0] hex_b;
  logic [7:0] move_count;
  logic       all_matched;
  logic [2:0] game_state;

  int n_checks = 0;
  int n_errors = 0;

  tile_round_controller #(
    .SHOW_CYCLES (SHOW_CYCLES),
    .BLINK_CYCLES(BLINK_CYCLES)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (start),
    .quit       (quit),
    .SW         (SW),
    .LEDR       (LEDR),
    .hex_a      (hex_a),
    .hex_b      (hex_b),
    .move_count (move_count),
    .all_matched(all_matched),
    .game_state (game_state)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_quit();
    quit = 1'b1;
    tick(1);
    quit = 1'b0;
  endtask

  task automatic pick(input int i);
    SW[i] = 1'b1;
    tick(3);
    SW[i] = 1'b0;
  endtask

  task automatic do_pair(input int a, input int b);
    pick(a);
    pick(b);
    tick(SHOW_CYCLES + 1);
  endtask

  task automatic play_all();
    do_pair(0, 7);
    do_pair(1, 4);
    do_pair(2, 6);
    do_pair(3, 5);
    do_pair(8, 9);
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    quit   = 1'b0;
    SW     = 10'd0;
    tick(2);
    resetn = 1'b1;
    tick(1);

    check("rst_state", game_state, 0);
    check("rst_ledr", LEDR, 10'h000);
    check("rst_hex_a", hex_a, 4'hF);
    check("rst_hex_b", hex_b, 4'hF);
    check("rst_moves", move_count, 0);
    check("rst_allm", all_matched, 0);

    // Matching pair 0/7, with the 3-edge switch latency
    pulse_start();
    check("t1_pick1", game_state, 1);
    SW[0] = 1'b1;
    tick(2);
    check("t1_latency", LEDR, 10'h000);
    tick(1);
    SW[0] = 1'b0;
    check("t1_led0", LEDR, 10'h001);
    check("t1_hex_a", hex_a, 4'h1);
    check("t1_hex_b_blank", hex_b, 4'hF);
    check("t1_pick2", game_state, 2);
    pick(7);
    check("t1_led07", LEDR, 10'h081);
    check("t1_hex_b", hex_b, 4'h1);
    check("t1_moves", move_count, 1);
    check("t1_show", game_state, 3);
    tick(SHOW_CYCLES - 1);
    check("t1_show_last", game_state, 3);
    tick(1);
    check("t1_resolve", game_state, 4);
    tick(1);
    check("t1_back_pick1", game_state, 1);
    check("t1_matched", LEDR, 10'h081);
    check("t1_hex_clear", hex_a, 4'hF);

    // Mismatch 0/1 and the blink pattern during SHOW
    pulse_quit();
    check("t2_quit_moves", move_count, 1);
    pulse_start();
    check("t2_moves_clr", move_count, 0);
    pick(0);
    pick(1);
    for (int k = 0; k < SHOW_CYCLES; k++) begin
      logic vis;
      vis = ((k / BLINK_CYCLES) % 2) == 0;
      check($sformatf("t2_blink_a%0d", k), hex_a, vis ? 4'h1 : 4'hF);
      check($sformatf("t2_blink_b%0d", k), hex_b, vis ? 4'h2 : 4'hF);
      check($sformatf("t2_led%0d", k), LEDR, 10'h003);
      tick(1);
    end
    check("t2_resolve", game_state, 4);
    tick(1);
    check("t2_led_clr", LEDR, 10'h000);
    check("t2_moves", move_count, 1);
    check("t2_pick1", game_state, 1);

    // Full game
    pulse_quit();
    pulse_start();
    play_all();
    check("t3_moves", move_count, 5);
    check("t3_allm", all_matched, 1);
    check("t3_done", game_state, 5);
    check("t3_led", LEDR, 10'h3FF);
    pulse_start();
    check("t3_restart", game_state, 1);
    check("t3_moves_clr", move_count, 0);
    check("t3_led_clr", LEDR, 10'h000);

    // Simultaneous edges and re-toggling a matched tile
    do_pair(0, 7);
    SW[2] = 1'b1;
    SW[5] = 1'b1;
    tick(3);
    SW[2] = 1'b0;
    SW[5] = 1'b0;
    check("t4_low_wins_led", LEDR, 10'h085);
    check("t4_hex_a", hex_a, 4'h3);
    check("t4_pick2", game_state, 2);
    pick(6);
    tick(SHOW_CYCLES + 1);
    check("t4_matched", LEDR, 10'h0C5);
    tick(3);
    pick(0);
    check("t4_matched_ignored", game_state, 1);
    check("t4_led_same", LEDR, 10'h0C5);

    // quit during SHOW, quit+start in DONE
    pick(3);
    pick(5);
    tick(2);
    check("t5_in_show", game_state, 3);
    pulse_quit();
    check("t5_idle", game_state, 0);
    check("t5_led", LEDR, 10'h000);
    check("t5_hex_a", hex_a, 4'hF);
    check("t5_hex_b", hex_b, 4'hF);
    check("t5_moves_kept", move_count, 3);
    pulse_start();
    play_all();
    check("t5_done", game_state, 5);
    quit  = 1'b1;
    start = 1'b1;
    tick(1);
    quit  = 1'b0;
    start = 1'b0;
    check("t5_quit_wins", game_state, 0);
    check("t5_quit_moves", move_count, 5);
    check("t5_quit_allm", all_matched, 0);

    // Reset during PICK2, then saturation
    pulse_start();
    do_pair(0, 1);
    pick(2);
    check("t6_pick2", game_state, 2);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    check("t6_rst_state", game_state, 0);
    check("t6_rst_led", LEDR, 10'h000);
    check("t6_rst_hex_a", hex_a, 4'hF);
    check("t6_rst_hex_b", hex_b, 4'hF);
    check("t6_rst_moves", move_count, 0);
    pulse_start();
    for (int n = 0; n < 255; n++) do_pair(0, 1);
    check("t6_moves_255", move_count, 255);
    do_pair(0, 1);
    check("t6_moves_sat", move_count, 255);
    check("t6_state", game_state, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tile_round_controller.md
Name: tile_round_controller

Overview:
- Sequences one tile-matching game on the DE1-SoC board: start, pick first tile, pick second tile, timed reveal with blink, match/mismatch resolution, all-matched detection.
- Consumes raw slide switches and the start/quit strobes from the top-level mode FSM.
- Drives LEDR, two color nibbles for hex_7seg (HEX2/HEX3), the move score and the all_matched flag back to the mode FSM.

Parameters:
- SHOW_CYCLES, 25000000: clock cycles the two revealed tiles are shown before resolution (0.5 s at 50 MHz); must be >= 2.
- BLINK_CYCLES, 6250000: half-period of hex blink during reveal; must be >= 1.
- TILE_COLORS, 30'h2D2E28D1: packed 3-bit color per tile. Tile i color is TILE_COLORS[3i+2:3i]. Default colors for tiles 0..9 are 1,2,3,4,2,4,3,1,5,5.

Ports:
- CLOCK_50, input, 1: system clock.
- resetn, input, 1: reset.
- start, input, 1: one-cycle pulse that begins a new game.
- quit, input, 1: one-cycle pulse that abandons the game.
- SW, input, 10: raw slide switches, asynchronous.
- LEDR, output, 10: matched tiles OR currently revealed tiles.
- hex_a, output, 4: color of the first revealed tile, or 4'hF for blank.
- hex_b, output, 4: color of the second revealed tile, or 4'hF for blank.
- move_count, output, 8: completed pair attempts; saturates at 255.
- all_matched, output, 1: high in DONE.
- game_state, output, 3: IDLE=0, PICK1=1, PICK2=2, SHOW=3, RESOLVE=4, DONE=5.

Behaviour:
- Reset: resetn is synchronous, active-low, on CLOCK_50.
  - State goes to IDLE.
  - matched, revealed, LEDR and move_count clear to 0.
  - hex_a and hex_b go to 4'hF.
  - all_matched goes to 0.
  - Switch synchronizers and the previous-value register load 0.
  - Reset mid-game aborts immediately with no partial update.
- Switch input path:
  - 2-flop synchronizer followed by a prev register.
  - sel[i] = sync[i] & ~prev[i] & ~matched[i] & ~revealed[i].
  - A physical rising edge is acted on exactly 3 clock edges after it is sampled.
  - If several sel bits are set in one cycle, the lowest index wins and the others are dropped; the user must re-toggle.
  - Falling edges are ignored.
- IDLE:
  - start moves to PICK1 and clears matched, revealed and move_count.
  - sel is ignored.
- PICK1:
  - On sel[i]: revealed[i]=1, idx1=i, hex_a={0,color(i)}, move to PICK2.
- PICK2:
  - On sel[j]: revealed[j]=1, idx2=j, hex_b={0,color(j)}.
  - Increment move_count, saturating at 255.
  - Load the reveal timer with SHOW_CYCLES-1 and the blink timer with BLINK_CYCLES-1.
  - Set vis=1 and move to SHOW.
- SHOW:
  - The reveal timer decrements every cycle.
  - The blink timer decrements; at 0 it reloads and toggles vis.
  - hex_a/hex_b show their colors when vis=1 and 4'hF when vis=0.
  - LEDR stays steady.
  - When the reveal timer reaches 0, move to RESOLVE; SHOW lasts exactly SHOW_CYCLES cycles.
  - sel is ignored.
- RESOLVE (one cycle):
  - If color(idx1)==color(idx2), set matched[idx1] and matched[idx2]; otherwise matched is unchanged.
  - Clear revealed and set hex_a=hex_b=4'hF.
  - Move to DONE if the next matched value == 10'h3FF, else to PICK1.
- DONE:
  - all_matched=1 and LEDR=10'h3FF.
  - start starts a new game exactly as in IDLE (PICK1, counters cleared).
  - quit moves to IDLE.
- quit in any state except IDLE:
  - Move to IDLE, clear matched and revealed, hex to 4'hF.
  - move_count holds its value until the next start.
- Priority, highest first: resetn, quit, start, sel. quit together with start or sel means the quit alone takes effect.
- Tile index is 4 bits. Colors are zero-extended to 4 bits. No tile may ever be both matched and revealed.

Test Plan (SHOW_CYCLES=8, BLINK_CYCLES=2):
- Reset, start, raise SW0 then SW7 -> LEDR 10'h001 then 10'h081; hex_a=1, hex_b=1; move_count=1; after 8 SHOW cycles plus RESOLVE: matched=10'h081, LEDR=10'h081, state=PICK1.
- Start, raise SW0 then SW1 (colors 1, 2) -> SHOW hex pattern visible 2 cycles, blank 2, visible 2, blank 2; after RESOLVE LEDR=0, move_count=1, state=PICK1.
- Play all 5 correct pairs -> move_count=5, all_matched=1, game_state=5, LEDR=10'h3FF; then start -> PICK1, move_count=0, LEDR=0.
- Raise SW2 and SW5 in the same cycle in PICK1 -> only tile 2 revealed (hex_a=3); toggling SW0 of an already-matched tile yields no selection.
- quit during SHOW with tiles 3 and 5 revealed -> next cycle IDLE, LEDR=0, hex=F/F, move_count retained; quit and start in the same cycle in DONE -> IDLE.
- resetn low for 1 cycle during PICK2 -> all outputs at their reset values; 256 mismatched attempts -> move_count holds at 255.
